window_fetcher: RTL and testbench
=================================

Name: window_fetcher

Overview:
Sequencer that gathers the 3x3 neighbourhood of one pixel from the 64x64 single-port image RAM for the median core. The image is stored column-major: addr = col*64 + row. On a start handshake it issues the nine neighbour reads and replaces out-of-image neighbours with a pad value. It then presents the full window, P11..P33, with a one-cycle valid pulse.

Parameters:
DATA_W, 8, pixel width
MEM_LAT, 1, RAM read latency in cycles (1..3), fixed
PAD_VALUE, 0, value substituted for neighbours outside the image

Ports:
iClk  in  1  clock
iRst  in  1  synchronous reset, active-high
iStart  in  1  request a window fetch; sampled only in IDLE
iStartRow  in  6  centre pixel row
iStartCol  in  6  centre pixel column
oBusy  out  1  fetch in progress; iStart ignored while high
oMemRe  out  1  RAM read enable
oMemAddr  out  12  RAM read address
iMemData  in  DATA_W  RAM read data, valid MEM_LAT cycles after oMemRe
oValid  out  1  one-cycle pulse: oP11..oP33 hold the new window
oP11,oP12,oP13,oP21,oP22,oP23,oP31,oP32,oP33  out  DATA_W each  window pixels; Pij has row offset i-2 and column offset j-2

Behaviour:
- One clock (iClk). Reset is synchronous, active-high (iRst), and fully synchronous.
- Reset values:
  - oBusy=0, oMemRe=0, oMemAddr=0, oValid=0.
  - All oPxx=0.
  - State=IDLE.
- States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On iStart=1, latch row/col, set slot index k=0 and go to ISSUE.
  - Call this cycle 0.
- ISSUE (cycles 1..9): slot k = cycle-1, in order P11,P12,P13,P21,P22,P23,P31,P32,P33.
  - Neighbour coordinates: r = row+dr, c = col+dc, with dr,dc in {-1,0,+1}.
  - Compute r and c in 7-bit signed arithmetic. The slot is pad if r<0, r>63, c<0 or c>63.
  - Non-pad slot: oMemRe=1, oMemAddr = c*64 + r (12 bits).
  - Pad slot: oMemRe=0, oMemAddr=0.
  - A pad tag is pipelined alongside the slot index for MEM_LAT cycles.
- Capture: at the end of cycle k+1+MEM_LAT, slot k's register loads iMemData, or PAD_VALUE if tagged pad.
- DRAIN: occupies cycles 10..9+MEM_LAT. oMemRe=0.
- DONE: occupies cycle 10+MEM_LAT.
  - oValid=1 for exactly that cycle; then return to IDLE.
  - Window outputs are updated at the end of the last capture cycle. They are held stable until the next fetch's DONE, so they are not partially updated early.
  - Implement by capturing into a shadow bank and copying it to oPxx when entering DONE.
- oBusy=1 from cycle 1 through the DONE cycle inclusive.
- iStart while oBusy=1 is ignored and not queued. The earliest next accept is the cycle after DONE.
- Latency: start accept to oValid = 10+MEM_LAT cycles (11 for the default).
- Throughput: one window per 11+MEM_LAT cycles.
- iStartRow/iStartCol are sampled only at accept; later changes have no effect.
- Reset mid-operation:
  - Immediately IDLE; oValid and oMemRe deasserted.
  - Shadow and output registers cleared to 0.
  - In-flight read data returning after reset is discarded.
- Simultaneous iRst and iStart: reset wins; no fetch starts.

Test Plan:
1. Interior centre row=10, col=20; RAM model data = addr[7:0]; MEM_LAT=1.
   - Addresses in cycles 1..9: 1225,1289,1353,1226,1290,1354,1227,1291,1355, with oMemRe=1 each cycle.
   - oValid at cycle 11; oP11..oP33 = 0xC9,0x09,0x49,0xCA,0x0A,0x4A,0xCB,0x0B,0x4B.
2. Corner row=0, col=0.
   - oMemRe low in slots 0,1,2,3,6.
   - Reads issued to 0, 64, 1, 65 (slots 4,5,7,8).
   - Window = 0,0,0, 0,0x00,0x40, 0,0x01,0x41.
3. Corner row=63, col=63.
   - Reads issued only to 4030, 4094, 4031, 4095 (slots 0,1,3,4).
   - P13, P23, P31, P32, P33 equal PAD_VALUE.
   - Set PAD_VALUE=0xFF to check that substitution uses the parameter.
4. Handshake: start row=5 col=5, then hold iStart=1 continuously.
   - Exactly one window per 12 cycles.
   - Second fetch accepted in the cycle after oValid.
   - Row/col changes during busy do not affect the addresses issued.
5. Reset at cycle 5 of a fetch.
   - Next cycle: oBusy=0, oMemRe=0, outputs 0.
   - No oValid follows.
   - A fresh start then produces a correct window at +11.
6. MEM_LAT=3 build, interior centre.
   - oValid at cycle 13.
   - Data matches test 1, confirming the tag pipeline alignment.

Source files
------------

// File: rtl/window_fetcher.sv
// Gathers the 3x3 neighbourhood of one pixel from a column-major 64x64 image RAM,
// substituting PAD_VALUE for out-of-image neighbours, and presents it with a valid pulse.
module window_fetcher #(
  parameter int                DATA_W    = 8,
  parameter int                MEM_LAT   = 1,
  parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [5:0]        iStartRow,
  input  logic [5:0]        iStartCol,
  output logic              oBusy,
  output logic              oMemRe,
  output logic [11:0]       oMemAddr,
  input  logic [DATA_W-1:0] iMemData,
  output logic              oValid,
  output logic [DATA_W-1:0] oP11,
  output logic [DATA_W-1:0] oP12,
  output logic [DATA_W-1:0] oP13,
  output logic [DATA_W-1:0] oP21,
  output logic [DATA_W-1:0] oP22,
  output logic [DATA_W-1:0] oP23,
  output logic [DATA_W-1:0] oP31,
  output logic [DATA_W-1:0] oP32,
  output logic [DATA_W-1:0] oP33
);

  // state  | meaning
  // IDLE   | waiting for iStart; centre coordinates latched on accept
  // ISSUE  | one neighbour slot per cycle, read issued unless padded
  // DRAIN  | waiting MEM_LAT cycles for the last read to return
  // DONE   | window outputs hold the new window; oValid high
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [5:0]        r_row;
  logic [5:0]        r_col;
  logic [3:0]        r_slot;
  logic [1:0]        r_drain_cnt;
  logic [6:0]        w_dr;
  logic [6:0]        w_dc;
  logic [6:0]        w_r;
  logic [6:0]        w_c;
  logic              w_pad;
  logic              w_issue;
  logic [MEM_LAT-1:0] r_tag_vld;
  logic [MEM_LAT-1:0] r_tag_pad;
  logic [3:0]        r_tag_slot [MEM_LAT];
  logic [DATA_W-1:0] r_shadow     [9];
  logic [DATA_W-1:0] w_shadow_nxt [9];
  logic [DATA_W-1:0] r_win        [9];

  always_ff @(posedge iClk) begin
    if (iRst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    oBusy       = 1'b1;
    oValid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        oBusy = 1'b0;
        if (iStart) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: if (r_slot == 4'd8) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == 2'd0) w_state_nxt = S_DONE;
      S_DONE: begin
        oValid      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Slot k walks the window row-major: row offset k/3-1, column offset k%3-1.
  always_comb begin
    w_dr = 7'h7F;
    w_dc = 7'h7F;
    case (r_slot)
      4'd0, 4'd1, 4'd2: w_dr = 7'h7F;
      4'd3, 4'd4, 4'd5: w_dr = 7'h00;
      default:          w_dr = 7'h01;
    endcase
    case (r_slot)
      4'd0, 4'd3, 4'd6: w_dc = 7'h7F;
      4'd1, 4'd4, 4'd7: w_dc = 7'h00;
      default:          w_dc = 7'h01;
    endcase
  end

  // Bit 6 of the 7-bit sum flags both -1 and 64, i.e. any step off the image.
  assign w_r      = {1'b0, r_row} + w_dr;
  assign w_c      = {1'b0, r_col} + w_dc;
  assign w_pad    = w_r[6] | w_c[6];
  assign w_issue  = (r_state == S_ISSUE);
  assign oMemRe   = w_issue & ~w_pad;
  assign oMemAddr = oMemRe ? {w_c[5:0], w_r[5:0]} : 12'd0;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_row       <= '0;
      r_col       <= '0;
      r_slot      <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && iStart) begin
        r_row  <= iStartRow;
        r_col  <= iStartCol;
        r_slot <= '0;
      end
      if (w_issue) begin
        r_slot <= r_slot + 4'd1;
        if (r_slot == 4'd8) r_drain_cnt <= 2'(MEM_LAT - 1);
      end
      if (r_state == S_DRAIN && r_drain_cnt != 2'd0) r_drain_cnt <= r_drain_cnt - 2'd1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_tag_vld <= '0;
      r_tag_pad <= '0;
      for (int i = 0; i < MEM_LAT; i++) r_tag_slot[i] <= '0;
    end else begin
      r_tag_vld[0]  <= w_issue;
      r_tag_pad[0]  <= w_pad;
      r_tag_slot[0] <= r_slot;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_pad[i]  <= r_tag_pad[i-1];
        r_tag_slot[i] <= r_tag_slot[i-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) w_shadow_nxt[i] = r_shadow[i];
    if (r_tag_vld[MEM_LAT-1])
      w_shadow_nxt[r_tag_slot[MEM_LAT-1]] = r_tag_pad[MEM_LAT-1] ? PAD_VALUE : iMemData;
  end

  // The last capture and the copy to the outputs share one edge, so copy the next-shadow value.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < 9; i++) begin
        r_shadow[i] <= '0;
        r_win[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 9; i++) r_shadow[i] <= w_shadow_nxt[i];
      if (r_state == S_DRAIN && w_state_nxt == S_DONE)
        for (int i = 0; i < 9; i++) r_win[i] <= w_shadow_nxt[i];
    end
  end

  assign oP11 = r_win[0];
  assign oP12 = r_win[1];
  assign oP13 = r_win[2];
  assign oP21 = r_win[3];
  assign oP22 = r_win[4];
  assign oP23 = r_win[5];
  assign oP31 = r_win[6];
  assign oP32 = r_win[7];
  assign oP33 = r_win[8];

endmodule

// File: tb/tb_window_fetcher.sv
// Bench for window_fetcher: three builds (lat1/pad0, lat1/padFF, lat3/pad0) share stimulus;
// a cycle-accurate scoreboard predicts reads, valid timing and windows for each.
module tb_window_fetcher;

  typedef struct packed {
    logic [31:0]       acc;
    logic [0:8]        re;
    logic [0:8][11:0]  addr;
    logic [0:8][7:0]   win;
  } exp_t;

  typedef struct {
    logic [5:0]      row;
    logic [5:0]      col;
    logic [0:8]      re;
    logic [0:8][7:0] w0;
    logic [0:8][7:0] wf;
  } vec_t;

  logic clk = 1'b0;
  logic iRst, iStart;
  logic [5:0] iStartRow, iStartCol;

  logic [2:0]             busy, memre, valid;
  logic [2:0][11:0]       addr;
  logic [2:0][7:0]        mdata;
  logic [2:0][0:8][7:0]   win;
  logic [2:0][2:0][7:0]   rpipe;

  exp_t  sb_q [3][$];
  logic [0:8][7:0] last_win [3];
  int    free_cyc [3];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  int    tbl_sel = -1;
  bit    rst_seen = 0;
  vec_t  tbl [4];

  exp_t       h;
  exp_t       e;
  bit         have;
  int         d;
  logic       ex_re, ex_v;
  logic [11:0] ex_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  window_fetcher #(.DATA_W(8), .MEM_LAT(1), .PAD_VALUE(8'h00)) dut_a (
    .iClk(clk), .iRst(iRst), .iStart(iStart), .iStartRow(iStartRow), .iStartCol(iStartCol),
    .oBusy(busy[0]), .oMemRe(memre[0]), .oMemAddr(addr[0]), .iMemData(mdata[0]), .oValid(valid[0]),
    .oP11(win[0][0]), .oP12(win[0][1]), .oP13(win[0][2]), .oP21(win[0][3]), .oP22(win[0][4]),
    .oP23(win[0][5]), .oP31(win[0][6]), .oP32(win[0][7]), .oP33(win[0][8]));

  window_fetcher #(.DATA_W(8), .MEM_LAT(1), .PAD_VALUE(8'hFF)) dut_b (
    .iClk(clk), .iRst(iRst), .iStart(iStart), .iStartRow(iStartRow), .iStartCol(iStartCol),
    .oBusy(busy[1]), .oMemRe(memre[1]), .oMemAddr(addr[1]), .iMemData(mdata[1]), .oValid(valid[1]),
    .oP11(win[1][0]), .oP12(win[1][1]), .oP13(win[1][2]), .oP21(win[1][3]), .oP22(win[1][4]),
    .oP23(win[1][5]), .oP31(win[1][6]), .oP32(win[1][7]), .oP33(win[1][8]));

  window_fetcher #(.DATA_W(8), .MEM_LAT(3), .PAD_VALUE(8'h00)) dut_c (
    .iClk(clk), .iRst(iRst), .iStart(iStart), .iStartRow(iStartRow), .iStartCol(iStartCol),
    .oBusy(busy[2]), .oMemRe(memre[2]), .oMemAddr(addr[2]), .iMemData(mdata[2]), .oValid(valid[2]),
    .oP11(win[2][0]), .oP12(win[2][1]), .oP13(win[2][2]), .oP21(win[2][3]), .oP22(win[2][4]),
    .oP23(win[2][5]), .oP31(win[2][6]), .oP32(win[2][7]), .oP33(win[2][8]));

  // RAM models: data = addr[7:0]; 0xEE when no read was issued.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      rpipe[i][0] <= memre[i] ? addr[i][7:0] : 8'hEE;
      rpipe[i][1] <= rpipe[i][0];
      rpipe[i][2] <= rpipe[i][1];
    end
  end
  assign mdata[0] = rpipe[0][0];
  assign mdata[1] = rpipe[1][0];
  assign mdata[2] = rpipe[2][2];

  function automatic int lat_of(int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic logic [7:0] pad_of(int i);
    return (i == 1) ? 8'hFF : 8'h00;
  endfunction

  function automatic exp_t make_exp(int row, int col, logic [7:0] pad, int acc);
    exp_t x;
    int r, c;
    logic [11:0] a;
    x.acc = 32'(acc);
    for (int k = 0; k < 9; k++) begin
      r = row + k / 3 - 1;
      c = col + k % 3 - 1;
      if (r < 0 || r > 63 || c < 0 || c > 63) begin
        x.re[k] = 1'b0; x.addr[k] = 12'd0; x.win[k] = pad;
      end else begin
        a = 12'(c * 64 + r);
        x.re[k] = 1'b1; x.addr[k] = a; x.win[k] = a[7:0];
      end
    end
    return x;
  endfunction

  task automatic check(string nm, int inst, logic [71:0] act, logic [71:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s[%0d] @cyc %0d: got %0h want %0h", nm, inst, cyc, act, expv);
    end
  endtask

  // Scoreboard: check this cycle's outputs, then model reset/accept at the coming edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_seen) begin
        have = (sb_q[i].size() > 0);
        if (have) h = sb_q[i][0];
        d       = have ? (cyc - int'(h.acc)) : -1;
        ex_v    = have && (d == 10 + lat_of(i));
        ex_re   = have && d >= 1 && d <= 9 && h.re[d-1];
        ex_addr = ex_re ? h.addr[d-1] : 12'd0;
        check("busy", i, 72'(busy[i]), 72'(have));
        check("memre_addr", i, 72'({memre[i], addr[i]}), 72'({ex_re, ex_addr}));
        check("valid", i, 72'(valid[i]), 72'(ex_v));
        if (ex_v) begin
          check("window", i, win[i], h.win);
          last_win[i] = h.win;
          void'(sb_q[i].pop_front());
        end else begin
          check("window_hold", i, win[i], last_win[i]);
        end
      end
      if (iRst) begin
        sb_q[i].delete();
        last_win[i] = '0;
        free_cyc[i] = cyc + 1;
      end else if (rst_seen && iStart && cyc >= free_cyc[i]) begin
        e = make_exp(int'(iStartRow), int'(iStartCol), pad_of(i), cyc);
        if (tbl_sel >= 0) begin
          e.re  = tbl[tbl_sel].re;
          e.win = (i == 1) ? tbl[tbl_sel].wf : tbl[tbl_sel].w0;
        end
        sb_q[i].push_back(e);
        free_cyc[i] = cyc + 11 + lat_of(i);
      end
    end
    if (iRst) rst_seen = 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(logic [5:0] r, logic [5:0] c);
    iStart = 1'b1; iStartRow = r; iStartCol = c;
    tick();
    iStart = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{row: 6'd10, col: 6'd20, re: 9'b111111111,
               w0: {8'hC9, 8'h09, 8'h49, 8'hCA, 8'h0A, 8'h4A, 8'hCB, 8'h0B, 8'h4B},
               wf: {8'hC9, 8'h09, 8'h49, 8'hCA, 8'h0A, 8'h4A, 8'hCB, 8'h0B, 8'h4B}};
    tbl[1] = '{row: 6'd0, col: 6'd0, re: 9'b000011011,
               w0: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h01, 8'h41},
               wf: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h40, 8'hFF, 8'h01, 8'h41}};
    tbl[2] = '{row: 6'd63, col: 6'd63, re: 9'b110110000,
               w0: {8'hBE, 8'hFE, 8'h00, 8'hBF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00},
               wf: {8'hBE, 8'hFE, 8'hFF, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    tbl[3] = '{row: 6'd63, col: 6'd0, re: 9'b011011000,
               w0: {8'h00, 8'h3E, 8'h7E, 8'h00, 8'h3F, 8'h7F, 8'h00, 8'h00, 8'h00},
               wf: {8'hFF, 8'h3E, 8'h7E, 8'hFF, 8'h3F, 8'h7F, 8'hFF, 8'hFF, 8'hFF}};

    iRst = 1'b1; iStart = 1'b0; iStartRow = '0; iStartCol = '0;
    repeat (3) tick();
    iRst = 1'b0;
    tick();

    for (int t = 0; t < 4; t++) begin
      tbl_sel = t;
      start(tbl[t].row, tbl[t].col);
      tbl_sel = -1;
      repeat (16) tick();
    end

    // Held start: back-to-back windows, coordinates scrambled while busy.
    iStart = 1'b1; iStartRow = 6'd5; iStartCol = 6'd5;
    tick();
    for (int n = 0; n < 40; n++) begin
      iStartRow = 6'($urandom_range(0, 63));
      iStartCol = 6'($urandom_range(0, 63));
      tick();
    end
    iStart = 1'b0;
    repeat (16) tick();

    // Reset in cycle 5 of a fetch, then a fresh fetch.
    start(6'd10, 6'd20);
    repeat (4) tick();
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    repeat (16) tick();
    start(6'd33, 6'd7);
    repeat (16) tick();

    // Reset and start together: reset wins.
    iRst = 1'b1; iStart = 1'b1; iStartRow = 6'd1; iStartCol = 6'd1;
    tick();
    iRst = 1'b0; iStart = 1'b0;
    repeat (16) tick();

    for (int n = 0; n < 6; n++) begin
      start(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      repeat (15) tick();
    end

    for (int i = 0; i < 3; i++) check("drained", i, 72'(sb_q[i].size()), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
